// File: rtl/rsv_pkg.sv
// -----------------------------------------------------------------------------
// rsv_pkg
// Shared definitions for the dispatch scheduler and its reservation-station
// bank: the execution-class encoding and the default station-to-class map.
//
// Contents:
//   cls_t             execution-class code (ALU, MEM, BR, MUL)
//   DEF_NUM_RSV       default number of reservation stations
//   DEF_CLS_W         default width of a class code
//   RSV_CLASS_DEFAULT packed station-to-class map, slice i = class of station i
// -----------------------------------------------------------------------------
package rsv_pkg;

   typedef enum logic [1:0] {
      CLS_ALU = 2'd0,
      CLS_MEM = 2'd1,
      CLS_BR  = 2'd2,
      CLS_MUL = 2'd3
   } cls_t;

   localparam int DEF_NUM_RSV = 4;
   localparam int DEF_CLS_W   = 2;

   // Station 0 is the ALU station, station 3 the MUL station.
   localparam logic [DEF_NUM_RSV*DEF_CLS_W-1:0] RSV_CLASS_DEFAULT =
      {CLS_MUL, CLS_BR, CLS_MEM, CLS_ALU};

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Rotating-priority picker. Scans the eligible mask upward from ptr, wrapping
// past the top, and returns the first set position. The search is purely
// combinational.
//
// Ports:
//   eligible  in  N      candidate mask
//   ptr       in  IDX_W  position with highest priority
//   onehot    out N      one-hot of the chosen position (0 if none)
//   idx       out IDX_W  index of the chosen position (0 if none)
//   found     out 1      at least one candidate was eligible
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     eligible,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   always_comb begin
      // NOTE: every output gets a default before the search loop; a path that
      // leaves one unassigned would infer a latch.
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      for (int off = 0; off < N; off++) begin
         int pos;
         pos = int'(ptr) + off;
         if (pos >= N) pos = pos - N;
         if (!found && eligible[pos]) begin
            found       = 1'b1;
            onehot[pos] = 1'b1;
            idx         = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/rsv_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// rsv_dispatch_ctrl
// Dispatch scheduler between the decoder and the reservation-station bank.
// Accepts one decoded instruction per cycle, picks a station of the matching
// execution class in round-robin order (one pointer shared by all classes),
// and tracks per-station free-slot credits so no station is overfilled.
// Stations return credits through release pulses; a flush refills them all.
//
// Ports:
//   clk           in  1              rising-edge clock
//   rst           in  1              synchronous active-high reset
//   dec_valid     in  1              decoded instruction offered
//   dec_cls       in  CLS_W          execution class of the offer
//   dec_instr     in  INSTR_W        decoded instruction payload
//   dec_ready     out 1              an eligible station with credit exists
//   disp_valid    out NUM_RSV        registered one-hot dispatch strobe
//   disp_instr    out INSTR_W        registered payload with disp_valid
//   rsv_release   in  NUM_RSV        per-station entry-freed pulses
//   flush         in  1              pipeline flush, refills every credit
//   rsv_credit    out NUM_RSV*CNT_W  free-slot count per station
//   err_overflow  out 1              sticky: release on an already full station
// -----------------------------------------------------------------------------
module rsv_dispatch_ctrl
   import rsv_pkg::*;
#(
   parameter int                       NUM_RSV   = DEF_NUM_RSV,
   parameter int                       RSV_DEPTH = 4,
   parameter int                       CLS_W     = DEF_CLS_W,
   parameter int                       INSTR_W   = 64,
   parameter logic [NUM_RSV*CLS_W-1:0] RSV_CLASS = RSV_CLASS_DEFAULT,
   localparam int                      CNT_W     = $clog2(RSV_DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       dec_valid,
   input  logic [CLS_W-1:0]           dec_cls,
   input  logic [INSTR_W-1:0]         dec_instr,
   output logic                       dec_ready,
   output logic [NUM_RSV-1:0]         disp_valid,
   output logic [INSTR_W-1:0]         disp_instr,
   input  logic [NUM_RSV-1:0]         rsv_release,
   input  logic                       flush,
   output logic [NUM_RSV*CNT_W-1:0]   rsv_credit,
   output logic                       err_overflow
);

   localparam int               PTR_W = (NUM_RSV > 1) ? $clog2(NUM_RSV) : 1;
   localparam logic [CNT_W-1:0] FULL  = CNT_W'(RSV_DEPTH);
   localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_RSV - 1);

   // State
   logic [CNT_W-1:0]   credit_q [NUM_RSV];
   logic [CNT_W-1:0]   credit_d [NUM_RSV];
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NUM_RSV-1:0] disp_valid_q, disp_valid_d;
   logic [INSTR_W-1:0] disp_instr_q, disp_instr_d;
   logic               err_q, err_d;

   // Selection
   logic [NUM_RSV-1:0] eligible;
   logic [NUM_RSV-1:0] pick_oh;
   logic [PTR_W-1:0]   pick_idx;
   logic               pick_found;
   logic               handshake;
   logic [NUM_RSV-1:0] sel;

   always_comb begin
      for (int i = 0; i < NUM_RSV; i++) begin
         eligible[i] = (RSV_CLASS[i*CLS_W +: CLS_W] == dec_cls) &&
                       (credit_q[i] != '0);
      end
   end

   rr_pick #(
      .N     (NUM_RSV),
      .IDX_W (PTR_W)
   ) u_pick (
      .eligible (eligible),
      .ptr      (rr_ptr_q),
      .onehot   (pick_oh),
      .idx      (pick_idx),
      .found    (pick_found)
   );

   // Readiness depends only on credits, class and flush, never on dec_valid,
   // so the decoder may use it to decide whether to offer at all.
   assign dec_ready = !flush && pick_found;
   assign handshake = dec_valid && dec_ready;
   assign sel       = handshake ? pick_oh : '0;

   // Credit bookkeeping. A release and a dispatch on the same station cancel.
   // A release arriving at a full, unselected station saturates and raises the
   // sticky error. During flush every station empties, so releases that cycle
   // refer to entries that no longer exist and are dropped.
   always_comb begin
      err_d = err_q;
      for (int i = 0; i < NUM_RSV; i++) begin
         credit_d[i] = credit_q[i];
         if (flush) begin
            credit_d[i] = FULL;
         end else if (rsv_release[i] && !sel[i]) begin
            if (credit_q[i] == FULL) begin
               err_d = 1'b1;
            end else begin
               credit_d[i] = credit_q[i] + CNT_W'(1);
            end
         end else if (sel[i] && !rsv_release[i]) begin
            credit_d[i] = credit_q[i] - CNT_W'(1);
         end
      end
   end

   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      disp_valid_d = sel;
      // Payload is only meaningful alongside disp_valid; holding it between
      // dispatches avoids toggling the wide output bus for nothing.
      disp_instr_d = disp_instr_q;
      if (handshake) begin
         rr_ptr_d     = (pick_idx == LAST) ? '0 : pick_idx + PTR_W'(1);
         disp_instr_d = dec_instr;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge values regardless of statement order.
      if (rst) begin
         for (int i = 0; i < NUM_RSV; i++) credit_q[i] <= FULL;
         rr_ptr_q     <= '0;
         disp_valid_q <= '0;
         disp_instr_q <= '0;
         err_q        <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_RSV; i++) credit_q[i] <= credit_d[i];
         rr_ptr_q     <= rr_ptr_d;
         disp_valid_q <= disp_valid_d;
         disp_instr_q <= disp_instr_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_RSV; i++) begin
         rsv_credit[i*CNT_W +: CNT_W] = credit_q[i];
      end
   end

   assign disp_valid   = disp_valid_q;
   assign disp_instr   = disp_instr_q;
   assign err_overflow = err_q;

endmodule
